// File: rtl/morphle_cfg_pkg.sv
// morphle_cfg_pkg: register map, control/status bit positions and loader FSM states
package morphle_cfg_pkg;
  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CBIT   = 3'd2;
  localparam logic [2:0] A_CAPT   = 3'd3;
  localparam logic [2:0] A_UIN    = 3'd4;
  localparam logic [2:0] A_UOUT   = 3'd5;
  localparam int C_BLK    = 0;
  localparam int C_FLUSH  = 1;
  localparam int C_CLROVF = 2;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_LVL   = 3;
  localparam int ST_OVF   = 6;
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;
endpackage

// File: rtl/morphle_cfg_fifo.sv
// morphle_cfg_fifo: synchronous FIFO of pending configuration words
module morphle_cfg_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_head,
  output logic [W-1:0]             o_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp, w_rn;
  logic w_push, w_pop;
  assign o_level = r_wp - r_rp;
  assign o_empty = o_level == '0;
  assign o_full  = o_level == (AW+1)'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign w_push  = i_push & (~o_full | w_pop);
  assign w_rn    = r_rp + 1'b1;
  assign o_head  = r_mem[r_rp[AW-1:0]];
  assign o_next  = r_mem[w_rn[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge i_clk)
    if (w_push && !i_flush) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

// File: rtl/morphle_cfg_loader.sv
// morphle_cfg_loader: Wishbone-driven confclk/cbitin sequencer and I/O window for a Morphle yblock
module morphle_cfg_loader
  import morphle_cfg_pkg::*;
#(
  parameter int BLOCKWIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int HIGH_CYC   = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    fab_reset,
  output logic                    confclk,
  output logic [BLOCKWIDTH-1:0]   cbitin,
  input  logic [BLOCKWIDTH-1:0]   cbitout,
  output logic [2*BLOCKWIDTH-1:0] uin,
  input  logic [2*BLOCKWIDTH-1:0] uout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t r_st, w_nxt;
  logic [7:0] r_tmr, w_ld;
  logic r_ack, r_blk, r_ovf, r_conf;
  logic [31:0] r_dat, r_uin, r_uout, w_rdata;
  logic [15:0] r_capt, r_cnt;
  logic [BLOCKWIDTH-1:0] r_cbit, w_head, w_next;
  logic w_acc, w_wr, w_wr_ctrl, w_push, w_pop, w_done, w_abort, w_flush, w_clr, w_full, w_empty, w_busy;
  logic [AW:0] w_lvl;
  logic w_unused;
  assign w_unused  = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
  assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr      = w_acc & wbs_we_i;
  assign w_wr_ctrl = w_wr & (wbs_adr_i[4:2] == A_CTRL);
  assign w_flush   = w_wr_ctrl & wbs_dat_i[C_FLUSH];
  assign w_clr     = w_wr_ctrl & wbs_dat_i[C_CLROVF];
  assign w_abort   = w_wr_ctrl & (wbs_dat_i[C_BLK] | wbs_dat_i[C_FLUSH]);
  assign w_push    = w_wr & (wbs_adr_i[4:2] == A_CBIT) & (wbs_sel_i[1:0] == 2'b11);
  assign w_busy    = r_st != IDLE;
  // an abort drops the in-flight word so only untouched entries survive
  assign w_pop     = w_done | (w_abort & w_busy);
  assign w_ld      = (w_nxt == SETUP) ? 8'(SETUP_CYC-1) : (w_nxt == HIGH) ? 8'(HIGH_CYC-1) : 8'(HOLD_CYC-1);
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign fab_reset = r_blk;
  assign confclk   = r_conf;
  assign cbitin    = r_cbit;
  assign uin       = (2*BLOCKWIDTH)'(r_uin);
  morphle_cfg_fifo #(.W(BLOCKWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_push(w_push), .i_pop(w_pop), .i_flush(w_flush),
    .i_din(wbs_dat_i[BLOCKWIDTH-1:0]), .o_head(w_head), .o_next(w_next),
    .o_full(w_full), .o_empty(w_empty), .o_level(w_lvl)
  );
  always_comb begin
    w_nxt  = r_st;
    w_done = 1'b0;
    case (r_st)
      IDLE:  w_nxt = (!w_empty && !r_blk) ? SETUP : IDLE;
      SETUP: w_nxt = (r_tmr == '0) ? HIGH : SETUP;
      HIGH:  w_nxt = (r_tmr == '0) ? HOLD : HIGH;
      HOLD: begin
        w_done = r_tmr == '0;
        w_nxt  = !w_done ? HOLD : (w_lvl[AW:1] != '0) ? SETUP : IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_nxt  = IDLE;
      w_done = 1'b0;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      r_st   <= IDLE;
      r_tmr  <= '0;
      r_conf <= 1'b0;
      r_cbit <= '0;
      r_capt <= '0;
      r_cnt  <= '0;
    end else begin
      r_st   <= w_nxt;
      r_tmr  <= (w_nxt != r_st) ? w_ld : r_tmr - {7'd0, |r_tmr};
      r_conf <= w_nxt == HIGH;
      // back-to-back words skip IDLE, so the word behind the popped head is loaded
      if (w_nxt == SETUP && r_st != SETUP) r_cbit <= (r_st == HOLD) ? w_next : w_head;
      if (w_done) begin
        r_capt <= 16'(cbitout);
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  always_comb begin
    w_rdata = '0;
    case (wbs_adr_i[4:2])
      A_CTRL: w_rdata[C_BLK] = r_blk;
      A_STATUS: begin
        w_rdata[ST_BUSY]     = w_busy;
        w_rdata[ST_FULL]     = w_full;
        w_rdata[ST_EMPTY]    = w_empty;
        w_rdata[ST_LVL +: 3] = 3'(w_lvl);
        w_rdata[ST_OVF]      = r_ovf;
      end
      A_CAPT:  w_rdata = {r_cnt, r_capt};
      A_UIN:   w_rdata = r_uin;
      A_UOUT:  w_rdata = r_uout;
      default: w_rdata = '0;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_blk  <= 1'b1;
      r_ovf  <= 1'b0;
      r_uin  <= '0;
      r_uout <= '0;
    end else begin
      r_ack  <= wbs_cyc_i & wbs_stb_i & ~r_ack;
      r_dat  <= (w_acc & ~wbs_we_i) ? w_rdata : '0;
      r_uout <= 32'(uout);
      r_ovf  <= (w_push & w_full & ~w_pop) | (r_ovf & ~w_clr);
      if (w_wr_ctrl) r_blk <= wbs_dat_i[C_BLK];
      if (w_wr && wbs_adr_i[4:2] == A_UIN)
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) r_uin[8*b +: 8] <= wbs_dat_i[8*b +: 8];
    end
endmodule

// File: tb/tb_morphle_cfg_loader.sv
// tb_morphle_cfg_loader: directed scenario tests for the Morphle configuration loader
module tb_morphle_cfg_loader;
  localparam logic [31:0] R_CTRL = 32'h00, R_STAT = 32'h04, R_CBIT = 32'h08;
  localparam logic [31:0] R_CAPT = 32'h0C, R_UIN = 32'h10, R_UOUT = 32'h14;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] dat = '0, adr = '0, dato;
  logic ack, fab_reset, confclk;
  logic [15:0] cbitin, cbitout = '0;
  logic [31:0] uin, uout = '0;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  morphle_cfg_loader dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .fab_reset(fab_reset), .confclk(confclk), .cbitin(cbitin), .cbitout(cbitout),
    .uin(uin), .uout(uout)
  );
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] q);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    if (!ack) begin total++; $display("FAIL wb_ack_timeout adr=%h", a); end
    q = dato;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb(1'b1, a, d, s, q);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    wb(1'b0, a, 32'h0, 4'hF, q);
  endtask
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_reset();
    logic [31:0] q;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr(R_CTRL, 32'h0, 4'hF);
    wr(R_UIN, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    total++; if (fab_reset !== 1'b1) $display("FAIL reset_fab_reset got=%b exp=1", fab_reset); else pass++;
    total++; if (confclk !== 1'b0) $display("FAIL reset_confclk got=%b exp=0", confclk); else pass++;
    total++; if (uin !== 32'h0) $display("FAIL reset_uin got=%h exp=0", uin); else pass++;
    total++; if (ack !== 1'b0 || dato !== 32'h0) $display("FAIL reset_bus ack=%b dat=%h exp 0/0", ack, dato); else pass++;
    @(negedge clk); rst_n = 1'b1;
    rd(R_STAT, q);
    total++; if (q !== 32'h04) $display("FAIL reset_status got=%h exp=00000004", q); else pass++;
    rd(R_CTRL, q);
    total++; if (q !== 32'h01) $display("FAIL reset_ctrl got=%h exp=00000001", q); else pass++;
    rd(R_CAPT, q);
    total++; if (q !== 32'h0) $display("FAIL reset_capt got=%h exp=00000000", q); else pass++;
  endtask
  task automatic test_single();
    logic [31:0] q;
    logic [7:0] cc;
    logic [15:0] cb1, cb2;
    wr(R_CTRL, 32'h0, 4'hF);
    cbitout = 16'hFFFF;
    wr(R_CBIT, 32'h0000_A5C3, 4'b0011);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      cc[k] = confclk;
      if (k == 1) cb1 = cbitin;
      if (k == 2) cb2 = cbitin;
      if (k == 6) cbitout = 16'h1234;
    end
    total++; if (cc !== 8'b0001_1000) $display("FAIL single_confclk_trace got=%b exp=00011000", cc); else pass++;
    total++; if (cb1 !== 16'hA5C3 || cb2 !== 16'hA5C3) $display("FAIL single_cbitin_setup got=%h,%h exp=a5c3", cb1, cb2); else pass++;
    rd(R_CAPT, q);
    total++; if (q !== 32'h0001_1234) $display("FAIL single_capt got=%h exp=00011234", q); else pass++;
    rd(R_STAT, q);
    total++; if (q !== 32'h04) $display("FAIL single_status got=%h exp=00000004", q); else pass++;
  endtask
  task automatic test_burst();
    logic [31:0] q;
    logic [15:0] seen [4];
    logic [15:0] e;
    logic prev;
    int n;
    do_reset();
    cbitout = 16'hBEEF;
    for (int i = 0; i < 5; i++) wr(R_CBIT, 32'h1111 * (i + 1), 4'b0011);
    rd(R_STAT, q);
    total++; if (q !== 32'h62) $display("FAIL burst_status_full got=%h exp=00000062", q); else pass++;
    wr(R_CTRL, 32'h0, 4'hF);
    n = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (confclk && !prev) begin
        if (n < 4) seen[n] = cbitin;
        n++;
      end
      prev = confclk;
    end
    total++; if (n !== 4) $display("FAIL burst_strobe_count got=%0d exp=4", n); else pass++;
    for (int i = 0; i < 4; i++) begin
      e = 16'(32'h1111 * (i + 1));
      total++; if (seen[i] !== e) $display("FAIL burst_order[%0d] got=%h exp=%h", i, seen[i], e); else pass++;
    end
    rd(R_CAPT, q);
    total++; if (q !== 32'h0004_BEEF) $display("FAIL burst_capt got=%h exp=0004beef", q); else pass++;
    rd(R_STAT, q);
    total++; if (q !== 32'h44) $display("FAIL burst_status_ovf got=%h exp=00000044", q); else pass++;
    wr(R_CTRL, 32'h4, 4'hF);
    rd(R_STAT, q);
    total++; if (q !== 32'h04) $display("FAIL burst_clr_ovf got=%h exp=00000004", q); else pass++;
  endtask
  task automatic test_abort();
    logic [31:0] q;
    logic [15:0] sv;
    logic prev, c1, c2;
    int n;
    wr(R_CBIT, 32'hAAAA, 4'b0011);
    wr(R_CBIT, 32'hBBBB, 4'b0011);
    n = 0;
    while (!confclk && n < 20) begin @(negedge clk); n++; end
    total++; if (!confclk) $display("FAIL abort_no_strobe got=0 exp=1"); else pass++;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = R_CTRL; dat = 32'h1; sel = 4'hF;
    @(negedge clk); c1 = confclk;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); c2 = confclk;
    total++; if (c1 !== 1'b0 || c2 !== 1'b0) $display("FAIL abort_confclk got=%b,%b exp=0,0", c1, c2); else pass++;
    rd(R_CAPT, q);
    total++; if (q !== 32'h0004_BEEF) $display("FAIL abort_capt got=%h exp=0004beef", q); else pass++;
    rd(R_STAT, q);
    total++; if (q !== 32'h08) $display("FAIL abort_status got=%h exp=00000008", q); else pass++;
    wr(R_CTRL, 32'h0, 4'hF);
    n = 0; prev = 1'b0; sv = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (confclk && !prev) begin sv = cbitin; n++; end
      prev = confclk;
    end
    total++; if (n !== 1 || sv !== 16'hBBBB) $display("FAIL abort_resume got=%0d strobes word=%h exp=1 bbbb", n, sv); else pass++;
    rd(R_CAPT, q);
    total++; if (q !== 32'h0005_BEEF) $display("FAIL abort_resume_capt got=%h exp=0005beef", q); else pass++;
  endtask
  task automatic test_flush();
    logic [31:0] q;
    logic hi;
    wr(R_CTRL, 32'h1, 4'hF);
    for (int i = 1; i <= 3; i++) wr(R_CBIT, 32'(i), 4'b0011);
    wr(R_CTRL, 32'h0, 4'hF);
    wr(R_CTRL, 32'h2, 4'hF);
    hi = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); hi |= confclk; end
    total++; if (hi !== 1'b0) $display("FAIL flush_confclk got=%b exp=0", hi); else pass++;
    rd(R_STAT, q);
    total++; if (q !== 32'h04) $display("FAIL flush_status got=%h exp=00000004", q); else pass++;
    rd(R_CAPT, q);
    total++; if (q !== 32'h0005_BEEF) $display("FAIL flush_capt got=%h exp=0005beef", q); else pass++;
  endtask
  task automatic test_datapath();
    logic [31:0] q;
    wr(R_UIN, 32'hDEAD_BEEF, 4'b0011);
    total++; if (uin !== 32'h0000_BEEF) $display("FAIL uin_low got=%h exp=0000beef", uin); else pass++;
    rd(R_UIN, q);
    total++; if (q !== 32'h0000_BEEF) $display("FAIL uin_read got=%h exp=0000beef", q); else pass++;
    wr(R_UIN, 32'h1234_5678, 4'b1100);
    total++; if (uin !== 32'h1234_BEEF) $display("FAIL uin_high got=%h exp=1234beef", uin); else pass++;
    uout = 32'h55AA_00FF;
    rd(R_UOUT, q);
    total++; if (q !== 32'h55AA_00FF) $display("FAIL uout_read got=%h exp=55aa00ff", q); else pass++;
    rd(32'h18, q);
    total++; if (q !== 32'h0) $display("FAIL unmapped_read got=%h exp=00000000", q); else pass++;
    wr(R_CBIT, 32'h7777, 4'b0001);
    rd(R_STAT, q);
    total++; if (q !== 32'h04) $display("FAIL cbit_partial_sel got=%h exp=00000004", q); else pass++;
  endtask
  task automatic test_back_to_back();
    logic [2:0] a;
    logic [31:0] q;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = R_STAT; sel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a[k] = ack;
      if (k == 0) q = dato;
    end
    cyc = 1'b0; stb = 1'b0;
    total++; if (a !== 3'b101) $display("FAIL ack_toggle got=%b exp=101 (k2..k0)", a); else pass++;
    total++; if (q !== 32'h04) $display("FAIL ack_read_data got=%h exp=00000004", q); else pass++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_abort();
    test_flush();
    test_datapath();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog_timeout passed=%0d total=%0d", pass, total);
    $fatal(1, "timeout");
  end
endmodule
